dma_multichan_regs: RTL
=======================

DMA_MULTICHAN_REGS -- requirements
Module: dma_multichan_regs

Interface
REQ-001 Parameter NUM_CH, default 4, number of DMA channels, legal range 1..8.
REQ-002 Parameter ADDR_W, default 32, width of the CPU address bus.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpu_wr_en  input  1  CPU write strobe, one write per cycle.
REQ-006 cpu_rd_en  input  1  CPU read strobe.
REQ-007 cpu_addr  input  ADDR_W  byte address; word-aligned.
REQ-008 cpu_wr_data  input  32  write data.
REQ-009 cpu_rd_data  output  32  registered read data.
REQ-010 cpu_rd_valid  output  1  high for one cycle when cpu_rd_data is valid.
REQ-011 ch_start  output  NUM_CH  one-cycle start pulse per channel.
REQ-012 ch_done  input  NUM_CH  one-cycle completion pulse per channel, from the engine.
REQ-013 ch_busy  output  NUM_CH  channel transfer in progress.
REQ-014 src_addr_flat, dstn_addr_flat, count_flat, ctrl_flat  output  NUM_CH*32 each  channel c occupies bits [32c+31:32c].
REQ-015 irq  output  1  level interrupt.

Function
REQ-016 Channel c register block SHALL sit at base c*0x10: +0x0 SRC, +0x4 COUNT, +0x8 CTRL, +0xC DSTN.
REQ-017 Global registers SHALL be: 0x100 STATUS (RO, bits[NUM_CH-1:0] = ch_busy), 0x104 IRQ_EN (RW), 0x108 IRQ_PEND (W1C), 0x10C ERR (W1C).
REQ-018 CTRL layout SHALL be: bit0 GO, bit1 direction (0 read, 1 write), bits[31:2] stored and returned unchanged.
REQ-019 A write to CTRL with GO=1 while the channel is idle and COUNT!=0 SHALL set ch_busy and assert ch_start for exactly one cycle; both take effect on the next edge.
REQ-020 A write to CTRL with GO=1 while the channel is idle and COUNT==0 SHALL NOT assert ch_start; it SHALL set IRQ_PEND[c] on the next edge and leave GO=0.
REQ-021 Per-channel state machine SHALL have states IDLE -> BUSY (on accepted GO) -> IDLE (on ch_done); ch_done in IDLE SHALL be ignored.
REQ-022 On ch_done in BUSY, the channel SHALL clear ch_busy and CTRL.GO and set IRQ_PEND[c] on the next edge.
REQ-023 Writes to SRC, COUNT, CTRL or DSTN of a BUSY channel SHALL be ignored and SHALL set ERR[c] on the next edge.
REQ-024 For W1C registers, writing 1 SHALL clear the bit; a set event and a clear on the same bit in the same cycle SHALL leave the bit set.
REQ-025 Reads SHALL have 1-cycle latency; a read and a write to the same address in the same cycle SHALL return the pre-write value.
REQ-026 Unmapped addresses and channel indices >= NUM_CH SHALL read 0 with cpu_rd_valid asserted; writes to them SHALL be ignored.
REQ-027 cpu_rd_data SHALL hold its last value while cpu_rd_valid is low.
REQ-028 irq SHALL be registered and equal to |(IRQ_PEND & IRQ_EN), one cycle after either register changes.

Reset
REQ-029 On reset low, the following SHALL be 0 asynchronously: all registers, ch_busy, ch_start, cpu_rd_data, cpu_rd_valid and irq; every channel state machine SHALL return to IDLE.
REQ-030 Reset asserted mid-transfer SHALL abort the channel state without any ch_start or IRQ_PEND side effects after release.

Configuration
REQ-031 Macro DMA_IRQ_EN defined: IRQ_EN, IRQ_PEND and irq SHALL behave as specified above.
REQ-032 Macro DMA_IRQ_EN undefined: IRQ_EN and IRQ_PEND SHALL read 0 and ignore writes, irq SHALL be tied 0, and STATUS/ERR/channel behaviour SHALL be unchanged.

Structure
REQ-033 Package dma_regs_pkg SHALL hold the register offsets, the global base 0x100, the channel stride 0x10, the CTRL bit indices and the channel state enum.
REQ-034 Sub-module dma_channel_regs SHALL implement one channel's four registers and state machine, instantiated NUM_CH times via generate.

Verification
REQ-035 Write SRC=0x1000, COUNT=8, DSTN=0x2000 on ch1, then CTRL=0x3 -> next cycle ch_start[1] pulses once and ch_busy[1]=1; STATUS reads 0x2.
REQ-036 While ch1 is busy, write COUNT=5 -> COUNT still reads 8 and ERR reads 0x2; write ERR=0x2 -> ERR reads 0.
REQ-037 With IRQ_EN=0x2, pulse ch_done[1] -> CTRL reads 0x2, IRQ_PEND reads 0x2 and irq=1; W1C of 0x2 issued in the same cycle as a new ch1 done -> IRQ_PEND stays 0x2.
REQ-038 Write CTRL=0x1 on ch0 with COUNT=0 -> no ch_start pulse and IRQ_PEND[0]=1.
REQ-039 Read 0x200 and read ch4 with NUM_CH=4 -> 0 with cpu_rd_valid=1; assert reset while ch2 is busy -> all outputs 0 and no spurious ch_start after release.

Source files
------------

// File: rtl/dma_regs_pkg.sv
// Shared register map, CTRL bit positions and channel state encoding for the
// multi-channel DMA register block.
package dma_regs_pkg;

   localparam logic [31:0] GLB_BASE  = 32'h0000_0100;
   localparam logic [31:0] CH_STRIDE = 32'h0000_0010;

   // Byte offsets inside a channel block
   localparam logic [3:0] OFF_SRC   = 4'h0;
   localparam logic [3:0] OFF_COUNT = 4'h4;
   localparam logic [3:0] OFF_CTRL  = 4'h8;
   localparam logic [3:0] OFF_DSTN  = 4'hC;

   // Byte offsets inside the global block
   localparam logic [3:0] OFF_STATUS   = 4'h0;
   localparam logic [3:0] OFF_IRQ_EN   = 4'h4;
   localparam logic [3:0] OFF_IRQ_PEND = 4'h8;
   localparam logic [3:0] OFF_ERR      = 4'hC;

   localparam int CTRL_GO  = 0;
   localparam int CTRL_DIR = 1;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_BUSY = 1'b1
   } ch_state_e;

   function automatic logic [3:0] ch_index(input logic [7:0] addr);
      return 4'(addr / CH_STRIDE[7:0]);
   endfunction

endpackage

// File: rtl/dma_channel_regs.sv
// One DMA channel: SRC/COUNT/CTRL/DSTN registers plus the IDLE/BUSY handshake
// with the engine; error and pending events are reported to the global block.
module dma_channel_regs
   import dma_regs_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [3:0]  wr_off,
   input  logic [31:0] wr_data,
   input  logic        done,
   output logic [31:0] src,
   output logic [31:0] count,
   output logic [31:0] ctrl,
   output logic [31:0] dstn,
   output logic        busy,
   output logic        start,
   output logic        err_set,
   output logic        pend_set
);

   ch_state_e state;
   logic      go_req;
   logic      go_ok;
   logic      done_hit;

   assign go_req   = wr_en && (wr_off == OFF_CTRL) && wr_data[CTRL_GO] && (state == CH_IDLE);
   assign go_ok    = go_req && (count != '0);
   assign done_hit = done && (state == CH_BUSY);

   // A GO with nothing to move completes immediately: pending, no start.
   assign pend_set = (go_req && (count == '0)) || done_hit;
   assign err_set  = wr_en && (state == CH_BUSY);
   assign busy     = (state == CH_BUSY);

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= CH_IDLE;
         start <= 1'b0;
         src   <= '0;
         count <= '0;
         ctrl  <= '0;
         dstn  <= '0;
      end else begin
         start <= go_ok;
         if (go_ok)
            state <= CH_BUSY;
         else if (done_hit)
            state <= CH_IDLE;

         if (wr_en && (state == CH_IDLE)) begin
            case (wr_off)
               OFF_SRC:   src   <= wr_data;
               OFF_COUNT: count <= wr_data;
               OFF_CTRL: begin
                  ctrl          <= wr_data;
                  ctrl[CTRL_GO] <= go_ok;
               end
               OFF_DSTN:  dstn  <= wr_data;
               default: ;
            endcase
         end

         if (done_hit)
            ctrl[CTRL_GO] <= 1'b0;
      end
   end

endmodule

// File: rtl/dma_multichan_regs.sv
// CPU-visible register file for NUM_CH DMA channels plus STATUS/IRQ_EN/IRQ_PEND/ERR.
// Define DMA_IRQ_EN to build the interrupt registers; otherwise they read 0 and irq is 0.
module dma_multichan_regs
   import dma_regs_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 32
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cpu_wr_en,
   input  logic                   cpu_rd_en,
   input  logic [ADDR_W-1:0]      cpu_addr,
   input  logic [31:0]            cpu_wr_data,
   output logic [31:0]            cpu_rd_data,
   output logic                   cpu_rd_valid,
   output logic [NUM_CH-1:0]      ch_start,
   input  logic [NUM_CH-1:0]      ch_done,
   output logic [NUM_CH-1:0]      ch_busy,
   output logic [NUM_CH*32-1:0]   src_addr_flat,
   output logic [NUM_CH*32-1:0]   dstn_addr_flat,
   output logic [NUM_CH*32-1:0]   count_flat,
   output logic [NUM_CH*32-1:0]   ctrl_flat,
   output logic                   irq
);

   logic              ch_hit;
   logic              glb_hit;
   logic              glb_wr;
   logic [3:0]        ch_idx;
   logic [3:0]        reg_off;
   logic [NUM_CH-1:0] ch_wr;
   logic [NUM_CH-1:0] err_set;
   logic [NUM_CH-1:0] pend_set;
   logic [NUM_CH-1:0] wr_mask;
   logic [NUM_CH-1:0] err_q;
   logic [NUM_CH-1:0] irq_en_q;
   logic [NUM_CH-1:0] irq_pend_q;
   logic [31:0]       rd_mux;
   logic              unused_addr;

   assign ch_hit      = cpu_addr < ADDR_W'(GLB_BASE);
   assign glb_hit     = (cpu_addr >> 4) == ADDR_W'(GLB_BASE >> 4);
   assign ch_idx      = ch_index(cpu_addr[7:0]);
   assign reg_off     = {cpu_addr[3:2], 2'b00};
   assign glb_wr      = cpu_wr_en && glb_hit;
   assign wr_mask     = cpu_wr_data[NUM_CH-1:0];
   assign unused_addr = ^cpu_addr[1:0];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_wr[c] = cpu_wr_en && ch_hit && (ch_idx == 4'(c));

      dma_channel_regs u_ch (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (ch_wr[c]),
         .wr_off   (reg_off),
         .wr_data  (cpu_wr_data),
         .done     (ch_done[c]),
         .src      (src_addr_flat[32*c +: 32]),
         .count    (count_flat[32*c +: 32]),
         .ctrl     (ctrl_flat[32*c +: 32]),
         .dstn     (dstn_addr_flat[32*c +: 32]),
         .busy     (ch_busy[c]),
         .start    (ch_start[c]),
         .err_set  (err_set[c]),
         .pend_set (pend_set[c])
      );
   end

   // W1C: a same-cycle set event wins over the clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= '0;
      else
         err_q <= (err_q & ~((glb_wr && reg_off == OFF_ERR) ? wr_mask : '0)) | err_set;
   end

`ifdef DMA_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en_q   <= '0;
         irq_pend_q <= '0;
         irq        <= 1'b0;
      end else begin
         if (glb_wr && reg_off == OFF_IRQ_EN)
            irq_en_q <= wr_mask;
         irq_pend_q <= (irq_pend_q & ~((glb_wr && reg_off == OFF_IRQ_PEND) ? wr_mask : '0))
                       | pend_set;
         irq        <= |(irq_pend_q & irq_en_q);
      end
   end
`else
   logic unused_pend;
   assign unused_pend = |pend_set;
   assign irq_en_q    = '0;
   assign irq_pend_q  = '0;
   assign irq         = 1'b0;
`endif

   // NOTE: default first so every path assigns rd_mux and no latch is inferred.
   always_comb begin
      rd_mux = '0;
      if (ch_hit) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
               case (reg_off)
                  OFF_SRC:   rd_mux = src_addr_flat[32*c +: 32];
                  OFF_COUNT: rd_mux = count_flat[32*c +: 32];
                  OFF_CTRL:  rd_mux = ctrl_flat[32*c +: 32];
                  OFF_DSTN:  rd_mux = dstn_addr_flat[32*c +: 32];
                  default: ;
               endcase
            end
         end
      end else if (glb_hit) begin
         case (reg_off)
            OFF_STATUS:   rd_mux = 32'(ch_busy);
            OFF_IRQ_EN:   rd_mux = 32'(irq_en_q);
            OFF_IRQ_PEND: rd_mux = 32'(irq_pend_q);
            OFF_ERR:      rd_mux = 32'(err_q);
            default: ;
         endcase
      end
   end

   // Read data is captured from pre-edge register values, so a same-cycle
   // write to the same address returns the old contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_rd_data  <= '0;
         cpu_rd_valid <= 1'b0;
      end else begin
         cpu_rd_valid <= cpu_rd_en;
         if (cpu_rd_en)
            cpu_rd_data <= rd_mux;
      end
   end

endmodule
